// File: rtl/cpu_mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO: mult WIDTH/MUL_BITS_PER_CY+1 cycles, div WIDTH+1, div-by-zero 1.
// start is accepted only while busy=0; starts and HI/LO writes arriving during an operation are dropped.
module cpu_mult_div_unit #(
  parameter int WIDTH           = 32,
  parameter int MUL_BITS_PER_CY = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int K         = MUL_BITS_PER_CY;
  localparam int MUL_STEPS = WIDTH / K;
  localparam int CW        = $clog2(WIDTH);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_STEPS - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state_q;
  logic                 is_div_q;
  logic                 zdiv_q;
  logic                 qneg_q;
  logic                 rneg_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opnd_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 dbz_q;

  logic                 sgn_a;
  logic                 sgn_b;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH+K-1:0]   partial;
  logic [WIDTH+K-1:0]   mul_sum;
  logic [2*WIDTH-1:0]   acc_mul_d;
  logic [2*WIDTH-1:0]   acc_div_d;
  logic [2*WIDTH-1:0]   prod_neg;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       diff;
  logic [WIDTH-1:0]     hi_fix_d;
  logic [WIDTH-1:0]     lo_fix_d;

  always_comb begin
    sgn_a = ~op[0] & a_in[WIDTH-1];
    sgn_b = ~op[0] & b_in[WIDTH-1];
    a_mag = sgn_a ? -a_in : a_in;
    b_mag = sgn_b ? -b_in : b_in;
  end

  // acc = {running upper sum, unconsumed multiplier bits}; K bits retired per step.
  always_comb begin
    partial = '0;
    for (int j = 0; j < K; j++) begin
      if (acc_q[j]) partial = partial + ({{K{1'b0}}, opnd_q} << j);
    end
    mul_sum   = {{K{1'b0}}, acc_q[2*WIDTH-1:WIDTH]} + partial;
    acc_mul_d = {mul_sum, acc_q[WIDTH-1:K]};
  end

  // acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  always_comb begin
    rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd_q};
    if (diff[WIDTH]) acc_div_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    else             acc_div_d = {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    prod_neg = -acc_q;
    hi_fix_d = acc_q[2*WIDTH-1:WIDTH];
    lo_fix_d = acc_q[WIDTH-1:0];
    if (!zdiv_q) begin
      if (is_div_q) begin
        if (qneg_q) lo_fix_d = -acc_q[WIDTH-1:0];
        if (rneg_q) hi_fix_d = -acc_q[2*WIDTH-1:WIDTH];
      end else if (qneg_q) begin
        hi_fix_d = prod_neg[2*WIDTH-1:WIDTH];
        lo_fix_d = prod_neg[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      zdiv_q   <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            busy_q   <= 1'b1;
            is_div_q <= op[1];
            qneg_q   <= sgn_a ^ sgn_b;
            rneg_q   <= sgn_a;
            if (op[1] && b_in == '0) begin
              // FIX passes acc straight through as {hi, lo}.
              zdiv_q  <= 1'b1;
              acc_q   <= {a_in, {WIDTH{1'b1}}};
              state_q <= FIX;
            end else begin
              zdiv_q  <= 1'b0;
              opnd_q  <= op[1] ? b_mag : a_mag;
              acc_q   <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
              cnt_q   <= op[1] ? DIV_LAST : MUL_LAST;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= is_div_q ? acc_div_d : acc_mul_d;
          if (cnt_q == '0) state_q <= FIX;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        FIX: begin
          hi_q    <= hi_fix_d;
          lo_q    <= lo_fix_d;
          done_q  <= 1'b1;
          dbz_q   <= zdiv_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_cpu_mult_div_unit.sv
// Directed and randomized checks of cpu_mult_div_unit against an arithmetic reference model.
module tb_cpu_mult_div_unit;

  localparam int W = 32;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic         start1  = 1'b0;
  logic         start4  = 1'b0;
  logic [1:0]   op      = 2'd0;
  logic [W-1:0] a_in    = '0;
  logic [W-1:0] b_in    = '0;
  logic         hi_we   = 1'b0;
  logic         lo_we   = 1'b0;
  logic [W-1:0] wdata   = '0;

  logic [W-1:0] hi1, lo1, hi4, lo4;
  logic         busy1, done1, dbz1, busy4, done4, dbz4;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_hi, exp_lo;

  cpu_mult_div_unit #(.WIDTH(W), .MUL_BITS_PER_CY(1)) u1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .op(op), .a_in(a_in), .b_in(b_in),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .hi(hi1), .lo(lo1),
    .busy(busy1), .done(done1), .div_by_zero(dbz1)
  );

  cpu_mult_div_unit #(.WIDTH(W), .MUL_BITS_PER_CY(4)) u4 (
    .clock(clock), .reset_n(reset_n), .start(start4), .op(op), .a_in(a_in), .b_in(b_in),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .hi(hi4), .lo(lo4),
    .busy(busy4), .done(done4), .div_by_zero(dbz4)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference results straight from integer arithmetic.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] mh, output logic [W-1:0] ml, output logic mz);
    logic signed [63:0] sa, sb, q64, r64;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    mz = 1'b0;
    p  = '0;
    if (o[1] && b == '0) begin
      mz = 1'b1;
      p  = {a, 32'hFFFF_FFFF};
    end else begin
      case (o)
        2'd0: p = sa * sb;
        2'd1: p = {32'd0, a} * {32'd0, b};
        2'd2: begin
          q64 = sa / sb;
          r64 = sa % sb;
          p   = {r64[31:0], q64[31:0]};
        end
        default: p = {a % b, a / b};
      endcase
    end
    mh = p[63:32];
    ml = p[31:0];
  endfunction

  task automatic launch(input bit use4, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o;
    a_in = a;
    b_in = b;
    if (use4) start4 = 1'b1;
    else      start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    start4 = 1'b0;
    hi_we  = 1'b0;
    lo_we  = 1'b0;
  endtask

  // Called one negedge after the start edge plus 'already' further cycles; returns in the done cycle.
  task automatic finish_op(input string tag, input bit use4, input logic [1:0] o,
                           input logic [W-1:0] a, input logic [W-1:0] b, input int already);
    int cyc;
    int lat;
    logic [W-1:0] mh, ml;
    logic mz;
    model(o, a, b, mh, ml, mz);
    if (o[1] && b == '0) lat = 1;
    else if (o[1])       lat = W + 1;
    else                 lat = use4 ? W / 4 + 1 : W + 1;
    if (lat > already) check({tag, " busy"}, use4 ? busy4 : busy1, 1);
    cyc = already;
    while (!(use4 ? done4 : done1) && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    check({tag, " latency"}, cyc, lat);
    check({tag, " hi"}, use4 ? hi4 : hi1, mh);
    check({tag, " lo"}, use4 ? lo4 : lo1, ml);
    check({tag, " div_by_zero"}, use4 ? dbz4 : dbz1, mz);
    check({tag, " busy at done"}, use4 ? busy4 : busy1, 0);
    exp_hi = mh;
    exp_lo = ml;
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    bit           r4;
    int           dcount;

    repeat (2) @(negedge clock);
    check("reset hi", hi1, 0);
    check("reset lo", lo1, 0);
    check("reset busy", busy1, 0);
    check("reset done", done1, 0);
    check("reset dbz", dbz1, 0);
    reset_n = 1'b1;
    @(negedge clock);

    hi_we = 1'b1; wdata = 32'h0000_CAFE;
    @(negedge clock);
    hi_we = 1'b0;
    check("mthi", hi1, 32'h0000_CAFE);
    lo_we = 1'b1; wdata = 32'h0000_BEEF;
    @(negedge clock);
    lo_we = 1'b0;
    check("mtlo", lo1, 32'h0000_BEEF);
    check("mthi kept", hi1, 32'h0000_CAFE);

    // T1 with an mthi in the start cycle: the write lands, then the product replaces it.
    hi_we = 1'b1; wdata = 32'h1234_5678;
    launch(0, 2'd0, 32'hFFFF_FFFD, 32'd7);
    check("T1 mthi with start", hi1, 32'h1234_5678);
    finish_op("T1 mult", 0, 2'd0, 32'hFFFF_FFFD, 32'd7, 0);
    check("T1 hi const", hi1, 32'hFFFF_FFFF);
    check("T1 lo const", lo1, 32'hFFFF_FFEB);
    @(negedge clock);
    check("T1 done pulse width", done1, 0);

    launch(0, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("T2 multu k1", 0, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("T2 hi const", hi1, 32'hFFFF_FFFE);
    launch(1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("T2 multu k4", 1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("T2 k4 lo const", lo4, 32'h0000_0001);

    launch(0, 2'd2, 32'hFFFF_FFF9, 32'd2);
    finish_op("T3 div", 0, 2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    check("T3 div lo const", lo1, 32'hFFFF_FFFD);
    launch(0, 2'd3, 32'hFFFF_FFF9, 32'd2);
    finish_op("T3 divu", 0, 2'd3, 32'hFFFF_FFF9, 32'd2, 0);
    check("T3 divu lo const", lo1, 32'h7FFF_FFFC);

    launch(0, 2'd3, 32'h0000_1234, 32'd0);
    finish_op("T4 divu by zero", 0, 2'd3, 32'h0000_1234, 32'd0, 0);
    check("T4 dbz lo const", lo1, 32'hFFFF_FFFF);
    launch(0, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("T4 div overflow", 0, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("T4 overflow lo const", lo1, 32'h8000_0000);

    // T5: second start plus mthi during a running mult must both be dropped.
    ra = $urandom; rb = $urandom;
    launch(0, 2'd0, ra, rb);
    repeat (4) @(negedge clock);
    op = 2'd3; a_in = 32'h0000_0BAD; b_in = 32'd0;
    start1 = 1'b1; hi_we = 1'b1; wdata = 32'h0000_AAAA;
    @(negedge clock);
    start1 = 1'b0; hi_we = 1'b0;
    check("T5 hi unchanged while busy", hi1, exp_hi);
    finish_op("T5 mult", 0, 2'd0, ra, rb, 5);
    launch(0, 2'd3, 32'hDEAD_BEEF, 32'd13);
    finish_op("T5 start in done cycle", 0, 2'd3, 32'hDEAD_BEEF, 32'd13, 0);

    // Back-to-back randomized ops, each started in the previous done cycle.
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case (i % 8)
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      r4 = (ro[1] == 1'b0) && (i % 3 == 0);
      launch(r4, ro, ra, rb);
      finish_op($sformatf("rand%0d op%0d", i, ro), r4, ro, ra, rb, 0);
    end

    // T6: reset in the middle of a divide.
    launch(0, 2'd2, 32'h7654_3210, 32'd37);
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("T6 busy after reset", busy1, 0);
    check("T6 done after reset", done1, 0);
    check("T6 hi after reset", hi1, 0);
    check("T6 lo after reset", lo1, 0);
    @(negedge clock);
    reset_n = 1'b1;
    dcount = 0;
    repeat (40) begin
      @(negedge clock);
      if (done1) dcount++;
    end
    check("T6 no done after abort", dcount, 0);
    lo_we = 1'b1; wdata = 32'h0000_0055;
    @(negedge clock);
    lo_we = 1'b0;
    check("T6 mtlo after reset", lo1, 32'h0000_0055);
    check("T6 hi stays zero", hi1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
